frame_pad_rebuild: RTL and testbench

- Reverse of the edge-trimming sample selector. It takes the windowed stream of frame_width-2*select_cnt samples per frame and rebuilds full frame_width-sample frames.
- The trimmed head and tail are filled with pad_value. Frame boundaries are marked with sof/eof for the downstream FFT/phase stage.
- Both sides use a valid/ready handshake, and the output is registered.

---
 rtl/frame_pkg.sv | 21 ++
 rtl/frame_out_reg.sv | 33 +++
 rtl/frame_pad_rebuild.sv | 128 ++++++++++++
 tb/tb_frame_pad_rebuild.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// Shared types and size helpers for the frame padding rebuilder.
package frame_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    POST = 2'd3
  } state_t;

  localparam int FC_WIDTH = 16;

  function automatic int win_len(input int frame_width, input int select_cnt);
    return frame_width - 2 * select_cnt;
  endfunction

  function automatic int idx_width(input int frame_width);
    return (frame_width > 1) ? $clog2(frame_width) : 1;
  endfunction

endpackage

// File: rtl/frame_out_reg.sv
// Output register slice: captures a new beat whenever the slot is free or drained,
// otherwise holds data/sof/eof/valid stable for the downstream stage.
module frame_out_reg #(
  parameter int data_width = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  in_valid,
  input  logic [data_width-1:0] in_data,
  input  logic                  in_sof,
  input  logic                  in_eof,
  output logic                  m_valid,
  output logic [data_width-1:0] m_data,
  output logic                  m_sof,
  output logic                  m_eof
);

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_sof   <= 1'b0;
      m_eof   <= 1'b0;
    end else if (load) begin
      m_valid <= in_valid;
      m_data  <= in_data;
      m_sof   <= in_sof;
      m_eof   <= in_eof;
    end
  end

endmodule

// File: rtl/frame_pad_rebuild.sv
// Rebuilds full frames from a trimmed window: pads select_cnt beats before and
// after the window and marks frame boundaries with sof/eof.
module frame_pad_rebuild
  import frame_pkg::*;
#(
  parameter int                    select_cnt  = 26,
  parameter int                    frame_width = 256,
  parameter int                    data_width  = 32,
  parameter logic [data_width-1:0] pad_value   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [data_width-1:0] s_data,
  input  logic                  s_valid,
  input  logic                  s_sof,
  output logic                  s_ready,
  output logic [data_width-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_sof,
  output logic                  m_eof,
  output logic [FC_WIDTH-1:0]   frame_count,
  output logic                  sof_err
);

  localparam int WIN_LEN = win_len(frame_width, select_cnt);
  localparam int IW      = idx_width(frame_width);

  localparam logic [IW-1:0] PRE_LAST   = IW'(select_cnt - 1);
  localparam logic [IW-1:0] WIN_FIRST  = IW'(select_cnt);
  localparam logic [IW-1:0] WIN_LAST   = IW'(select_cnt + WIN_LEN - 1);
  localparam logic [IW-1:0] FRAME_LAST = IW'(frame_width - 1);

  state_t          state;
  logic [IW-1:0]   index;
  logic            load;
  logic            take;

  logic                  emit_valid;
  logic [data_width-1:0] emit_data;
  logic                  emit_sof;
  logic                  emit_eof;

  assign load    = !m_valid || m_ready;
  // Forced low during reset so a coincident handshake never consumes a sample.
  assign s_ready = (state == DATA) && load && !rst;
  assign take    = s_valid && s_ready;

  always_comb begin
    emit_valid = 1'b0;
    emit_data  = pad_value;
    emit_sof   = 1'b0;
    emit_eof   = 1'b0;
    case (state)
      PRE: begin
        emit_valid = 1'b1;
        emit_sof   = (index == '0);
      end
      DATA: begin
        if (take) begin
          emit_valid = 1'b1;
          emit_data  = s_data;
        end
      end
      POST: begin
        emit_valid = 1'b1;
        emit_eof   = (index == FRAME_LAST);
      end
      default: begin
        emit_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      index       <= '0;
      frame_count <= '0;
      sof_err     <= 1'b0;
    end else if (load) begin
      case (state)
        IDLE: begin
          if (s_valid) state <= PRE;
        end
        PRE: begin
          index <= index + 1'b1;
          if (index == PRE_LAST) state <= DATA;
        end
        DATA: begin
          if (take) begin
            index <= index + 1'b1;
            // sof must appear exactly on the first window sample; no resync on error.
            if (s_sof != (index == WIN_FIRST)) sof_err <= 1'b1;
            if (index == WIN_LAST) state <= POST;
          end
        end
        POST: begin
          if (index == FRAME_LAST) begin
            index       <= '0;
            frame_count <= frame_count + 1'b1;
            state       <= s_valid ? PRE : IDLE;
          end else begin
            index <= index + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  frame_out_reg #(
    .data_width(data_width)
  ) u_out (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .in_valid(emit_valid),
    .in_data (emit_data),
    .in_sof  (emit_sof),
    .in_eof  (emit_eof),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_sof   (m_sof),
    .m_eof   (m_eof)
  );

endmodule

// File: tb/tb_frame_pad_rebuild.sv
// Directed bench for frame_pad_rebuild: drives windows, checks every rebuilt beat.
module tb_frame_pad_rebuild;

  localparam int SC = 26;
  localparam int FW = 256;
  localparam int DW = 32;
  localparam int WL = FW - 2 * SC;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_sof;
  logic          s_ready;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_sof;
  logic          m_eof;
  logic [15:0]   frame_count;
  logic          sof_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  frame_pad_rebuild #(
    .select_cnt (SC),
    .frame_width(FW),
    .data_width (DW),
    .pad_value  ('0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_sof      (s_sof),
    .s_ready    (s_ready),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_sof      (m_sof),
    .m_eof      (m_eof),
    .frame_count(frame_count),
    .sof_err    (sof_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transaction = one run of nframes windows; every accepted output beat is checked.
  task automatic run(input int nframes, input int ready_pct, input int gap_at,
                     input int gap_len, input int err_at, input int abort_at,
                     input logic [31:0] base, input string tag);
    int total_out, total_in, rcv, sent, win_idx, gap_left, bubbles, cyc, idx, f;
    logic [31:0] seq_in, exp_d, hold_data;
    logic hold_sof, hold_eof;
    bit prev_stall, aborted, in_gap;
    total_out = nframes * FW;
    total_in  = nframes * WL;
    rcv = 0; sent = 0; win_idx = 0; gap_left = gap_len; bubbles = 0; cyc = 0;
    seq_in = base; prev_stall = 0; aborted = 0;
    hold_data = '0; hold_sof = 0; hold_eof = 0;
    while (rcv < total_out && cyc < 20000 && !aborted) begin
      @(negedge clk);
      cyc++;
      if (prev_stall) begin
        check({tag, "_stall_valid"}, 32'(m_valid), 32'(1));
        check({tag, "_stall_data"}, m_data, hold_data);
        check({tag, "_stall_sof"}, 32'(m_sof), 32'(hold_sof));
        check({tag, "_stall_eof"}, 32'(m_eof), 32'(hold_eof));
      end
      in_gap = (sent < total_in) && (win_idx == gap_at) && (gap_left > 0);
      if (in_gap) gap_left--;
      if (sent < total_in && !in_gap) begin
        s_valid = 1'b1;
        s_data  = seq_in;
        s_sof   = (win_idx == 0) || (win_idx == err_at);
      end else begin
        s_valid = 1'b0;
        s_data  = '0;
        s_sof   = 1'b0;
      end
      m_ready = (int'($urandom_range(99)) < ready_pct);
      if (rcv == abort_at) begin
        rst = 1'b1;
        #1;
        check({tag, "_rst_s_ready"}, 32'(s_ready), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        check({tag, "_rst_m_valid"}, 32'(m_valid), 32'(0));
        check({tag, "_rst_m_sof"}, 32'(m_sof), 32'(0));
        check({tag, "_rst_frame_count"}, 32'(frame_count), 32'(0));
        aborted = 1;
      end else begin
        #1;
        if (rcv > 0 && !m_valid) bubbles++;
        if (m_valid && m_ready) begin
          idx   = rcv % FW;
          f     = rcv / FW;
          exp_d = (idx >= SC && idx < SC + WL) ? base + 32'(f * WL + idx - SC) : 32'(0);
          check({tag, "_data"}, m_data, exp_d);
          check({tag, "_sof"}, 32'(m_sof), 32'(idx == 0));
          check({tag, "_eof"}, 32'(m_eof), 32'(idx == FW - 1));
          rcv++;
        end
        if (s_valid && s_ready) begin
          seq_in++;
          sent++;
          win_idx = (win_idx + 1) % WL;
        end
        prev_stall = m_valid && !m_ready;
        hold_data  = m_data;
        hold_sof   = m_sof;
        hold_eof   = m_eof;
      end
    end
    s_valid = 1'b0;
    s_sof   = 1'b0;
    m_ready = 1'b1;
    if (!aborted) begin
      check({tag, "_beats"}, 32'(rcv), 32'(total_out));
      if (ready_pct == 100) check({tag, "_bubbles"}, 32'(bubbles), 32'(gap_len));
      @(negedge clk);
    end
    $display("txn %s frames=%0d beats=%0d bubbles=%0d frame_count=%0d sof_err=%0b",
             tag, nframes, rcv, bubbles, frame_count, sof_err);
  endtask

  initial begin
    rst     = 1'b1;
    s_data  = '0;
    s_valid = 1'b1;
    s_sof   = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    check("rst_hold_s_ready", 32'(s_ready), 32'(0));
    @(negedge clk);
    rst     = 1'b0;
    s_valid = 1'b0;
    s_sof   = 1'b0;
    #1;
    check("reset_m_valid", 32'(m_valid), 32'(0));
    check("reset_m_data", m_data, 32'(0));
    check("reset_m_sof", 32'(m_sof), 32'(0));
    check("reset_m_eof", 32'(m_eof), 32'(0));
    check("reset_frame_count", 32'(frame_count), 32'(0));
    check("reset_sof_err", 32'(sof_err), 32'(0));
    check("reset_s_ready", 32'(s_ready), 32'(0));

    run(1, 100, -1, 0, -1, -1, 32'd1, "basic");
    check("basic_frame_count", 32'(frame_count), 32'(1));
    check("basic_sof_err", 32'(sof_err), 32'(0));

    run(1, 50, -1, 0, -1, -1, 32'd1, "random_ready");
    check("random_ready_frame_count", 32'(frame_count), 32'(2));

    run(1, 100, 100, 5, -1, -1, 32'h1000, "gap");
    check("gap_frame_count", 32'(frame_count), 32'(3));

    run(2, 100, -1, 0, -1, -1, 32'h2000, "back_to_back");
    check("b2b_frame_count", 32'(frame_count), 32'(5));
    check("b2b_sof_err", 32'(sof_err), 32'(0));

    run(1, 100, -1, 0, -1, 150, 32'h3000, "abort");
    run(1, 100, -1, 0, -1, -1, 32'h4000, "after_abort");
    check("after_abort_frame_count", 32'(frame_count), 32'(1));
    check("after_abort_sof_err", 32'(sof_err), 32'(0));

    run(1, 100, -1, 0, 50, -1, 32'h5000, "sof_err");
    check("sof_err_set", 32'(sof_err), 32'(1));
    check("sof_err_frame_count", 32'(frame_count), 32'(2));
    repeat (10) @(negedge clk);
    check("sof_err_sticky", 32'(sof_err), 32'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("sof_err_cleared", 32'(sof_err), 32'(0));
    check("sof_err_rst_frame_count", 32'(frame_count), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
